// File: rtl/wb_pkg.sv
// Shared types and sizes for the register-file write-back front end.
package wb_pkg;

  localparam int unsigned WB_XLEN    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;

  // One buffered long-latency result: destination register and its data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries; head is visible before pop.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head_c,
  output logic      full_c,
  output logic      empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_c = (wr_ptr_q == rd_ptr_q);
  assign full_c  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_c  = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full_c) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop && !empty_c) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/write_back_arbiter.sv
// Merges ALU and buffered LSU results onto the register-file write port and
// tracks outstanding long-latency destinations for decode hazard stalls.
module write_back_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN         = WB_XLEN,
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [XLEN-1:0]       aluData,
  output logic                  aluReady,
  input  logic                  lsuValid,
  input  logic [REG_ADDR_W-1:0] lsuRd,
  input  logic [XLEN-1:0]       lsuData,
  output logic                  lsuReady,
  input  logic                  issueValid,
  input  logic                  issueLong,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  hazardStall,
  output logic [REG_COUNT-1:0]  busyMask,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       writeData,
  output logic                  registerWrite
);

  localparam int unsigned     CNT_W         = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W-1:0] STARVE_THRESH = CNT_W'(STARVE_LIMIT - 1);

  wb_entry_t             push_entry;
  wb_entry_t             head;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop;
  logic                  starve, grant_alu, issue_set;

  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [REG_COUNT-1:0]  busy_q, busy_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  wen_q, wen_d;

  assign push_entry = '{rd: lsuRd, data: lsuData};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_c    (head),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // Arbitration: a waiting LSU head wins once it has waited long enough.
  assign starve      = !fifo_empty && (starve_cnt_q >= STARVE_THRESH);
  assign grant_alu   = aluValid && !starve;
  assign fifo_pop    = !fifo_empty && !grant_alu;
  assign aluReady    = reset && !starve;
  assign lsuReady    = reset && !fifo_full;
  assign fifo_push   = lsuValid && lsuReady;
  assign hazardStall = busy_q[rs1] | busy_q[rs2] | busy_q[issueRd];
  assign issue_set   = issueValid && issueLong && !hazardStall && (issueRd != '0);

  assign busyMask      = busy_q;
  assign rd            = rd_q;
  assign writeData     = wdata_q;
  assign registerWrite = wen_q;

  // Next-state for starve counter, write port and scoreboard.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    busy_d       = busy_q;
    rd_d         = rd_q;
    wdata_d      = wdata_q;
    wen_d        = 1'b0;

    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != '1) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (grant_alu) begin
      rd_d    = aluRd;
      wdata_d = aluData;
      wen_d   = (aluRd != '0);
    end else if (fifo_pop) begin
      rd_d               = head.rd;
      wdata_d            = head.data;
      wen_d              = (head.rd != '0);
      busy_d[head.rd]    = 1'b0;
    end

    // A newer long op to the same register outranks the completing one.
    if (issue_set) begin
      busy_d[issueRd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      busy_q       <= '0;
      rd_q         <= '0;
      wdata_q      <= '0;
      wen_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      busy_q       <= busy_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      wen_q        <= wen_d;
    end
  end

  // Decode must not issue while it is being told to stall.
  assert property (@(posedge clock) disable iff (!reset) !(issueValid && hazardStall))
    else $error("issue while hazardStall asserted");

  // A completing long result should correspond to a pending destination.
  assert property (@(posedge clock) disable iff (!reset)
                   !(fifo_pop && (head.rd != '0) && !busy_q[head.rd]))
    else $warning("lsu writeback to rd %0d with no pending long op", head.rd);

endmodule

// File: tb/tb_write_back_arbiter.sv
// Randomised and directed bench for write_back_arbiter against a queue-based model.
module tb_write_back_arbiter;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned FIFO_DEPTH   = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            issue_valid, issue_long;
  logic [4:0]      issue_rd, rs1, rs2;
  logic            hazard_stall;
  logic [31:0]     busy_mask;
  logic [4:0]      rd_o;
  logic [XLEN-1:0] wdata_o;
  logic            wen_o;

  write_back_arbiter #(
    .XLEN         (XLEN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock         (clk),
    .reset         (rst_n),
    .aluValid      (alu_valid),
    .aluRd         (alu_rd),
    .aluData       (alu_data),
    .aluReady      (alu_ready),
    .lsuValid      (lsu_valid),
    .lsuRd         (lsu_rd),
    .lsuData       (lsu_data),
    .lsuReady      (lsu_ready),
    .issueValid    (issue_valid),
    .issueLong     (issue_long),
    .issueRd       (issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .hazardStall   (hazard_stall),
    .busyMask      (busy_mask),
    .rd            (rd_o),
    .writeData     (wdata_o),
    .registerWrite (wen_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as queues, wait counter, pending set, write port.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  int unsigned m_cnt;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wdata;

  logic alu_acc = 1'b0, lsu_acc = 1'b0;
  logic last_alu_ready, last_lsu_ready, last_hazard;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_rd.delete();
    mq_data.delete();
    m_cnt   = 0;
    m_busy  = '0;
    m_wen   = 1'b0;
    m_rd    = '0;
    m_wdata = '0;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid   = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  function automatic logic in_fifo(input logic [4:0] r);
    foreach (mq_rd[i]) if (mq_rd[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check handshake/hazard outputs, advance the model, check write port.
  task automatic cycle();
    logic starve, lsu_rdy, hz, was_nonempty, popped;
    logic [4:0] prd;
    #1;
    starve  = (mq_rd.size() != 0) && (m_cnt >= STARVE_LIMIT - 1);
    lsu_rdy = mq_rd.size() < int'(FIFO_DEPTH);
    hz      = m_busy[rs1] | m_busy[rs2] | m_busy[issue_rd];
    last_alu_ready = alu_ready;
    last_lsu_ready = lsu_ready;
    last_hazard    = hazard_stall;
    check_eq("alu_ready", 32'(alu_ready), 32'(!starve));
    check_eq("lsu_ready", 32'(lsu_ready), 32'(lsu_rdy));
    check_eq("hazard_stall", 32'(hazard_stall), 32'(hz));

    alu_acc      = alu_valid && !starve;
    lsu_acc      = lsu_valid && lsu_rdy;
    was_nonempty = (mq_rd.size() != 0);
    popped       = 1'b0;
    if (alu_acc) begin
      m_wen = (alu_rd != 0); m_rd = alu_rd; m_wdata = alu_data;
    end else if (was_nonempty) begin
      prd = mq_rd.pop_front();
      m_wdata = mq_data.pop_front();
      m_rd = prd; m_wen = (prd != 0);
      m_busy[prd] = 1'b0;
      popped = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    if (!was_nonempty || popped) m_cnt = 0;
    else m_cnt++;
    if (issue_valid && issue_long && !hz && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (lsu_acc) begin
      mq_rd.push_back(lsu_rd);
      mq_data.push_back(lsu_data);
    end

    @(posedge clk); #1;
    check_eq("register_write", 32'(wen_o), 32'(m_wen));
    check_eq("rd", 32'(rd_o), 32'(m_rd));
    check_eq("write_data", wdata_o, m_wdata);
    check_eq("busy_mask", busy_mask, m_busy);
    @(negedge clk);
  endtask

  // Random producers honouring hold-until-accepted and decode's stall rule.
  task automatic rand_stim(input logic drain);
    int unsigned off;
    logic [4:0] r;
    if (!alu_valid || alu_acc) begin
      alu_valid = !drain && ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
    end
    if (!lsu_valid || lsu_acc) begin
      lsu_valid = 1'b0;
      if (drain || $urandom_range(0, 2) == 0) begin
        off = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          r = 5'((off + k) % 32);
          if (!lsu_valid && r != 0 && m_busy[r] && !in_fifo(r)) begin
            lsu_valid = 1'b1; lsu_rd = r; lsu_data = $urandom;
          end
        end
      end
    end
    rs1        = 5'($urandom_range(0, 31));
    rs2        = 5'($urandom_range(0, 31));
    issue_rd   = 5'($urandom_range(0, 31));
    issue_long = ($urandom_range(0, 2) == 0);
    issue_valid = !drain && ($urandom_range(0, 1) == 1) &&
                  !(m_busy[rs1] | m_busy[rs2] | m_busy[issue_rd]);
  endtask

  task automatic issue_long_op(input logic [4:0] r);
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = r;
    cycle();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
  endtask

  initial begin
    logic done;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    check_eq("rst_register_write", 32'(wen_o), 32'd0);
    check_eq("rst_busy_mask", busy_mask, 32'd0);
    check_eq("rst_rd", 32'(rd_o), 32'd0);
    check_eq("rst_write_data", wdata_o, 32'd0);
    check_eq("rst_alu_ready", 32'(alu_ready), 32'd0);
    check_eq("rst_lsu_ready", 32'(lsu_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-traffic with two buffered results pending on x2 and x5.
    issue_long_op(5'd2);
    issue_long_op(5'd5);
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_00A1;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0000_0B02;
    cycle();
    lsu_rd = 5'd5; lsu_data = 32'h0000_0B05;
    cycle();
    idle_inputs();
    check_eq("pre_rst_busy", busy_mask, 32'h0000_0024);
    check_eq("pre_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_register_write", 32'(wen_o), 32'd0);
    check_eq("mid_rst_busy", busy_mask, 32'd0);
    check_eq("mid_rst_lsu_ready", 32'(lsu_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check_eq("post_rst_lsu_ready", 32'(last_lsu_ready), 32'd1);
    check_eq("post_rst_fifo_empty_no_write", 32'(wen_o), 32'd0);

    // ALU-only back-to-back writes.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
    cycle();
    check_eq("alu_first_rd", 32'(rd_o), 32'd5);
    check_eq("alu_first_data", wdata_o, 32'h11);
    alu_rd = 5'd6; alu_data = 32'h22;
    cycle();
    check_eq("alu_second_rd", 32'(rd_o), 32'd6);
    check_eq("alu_second_data", wdata_o, 32'h22);
    check_eq("alu_ready_held", 32'(last_alu_ready), 32'd1);
    alu_valid = 1'b0;

    // Long-op lifecycle on x7.
    issue_long_op(5'd7);
    check_eq("long_busy7_set", 32'(busy_mask[7]), 32'd1);
    rs1 = 5'd7;
    cycle();
    check_eq("long_hazard", 32'(last_hazard), 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD;
    cycle();
    lsu_valid = 1'b0;
    cycle();
    check_eq("long_write_rd", 32'(rd_o), 32'd7);
    check_eq("long_write_data", wdata_o, 32'hDEAD);
    check_eq("long_write_en", 32'(wen_o), 32'd1);
    check_eq("long_busy7_clear", 32'(busy_mask[7]), 32'd0);
    check_eq("long_hazard_clear", 32'(hazard_stall), 32'd0);
    rs1 = '0;

    // Starvation: ALU held valid while a result for x3 waits.
    issue_long_op(5'd3);
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h100;
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    cycle();
    lsu_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (alu_acc) alu_data = 32'h101 + 32'(k);
      cycle();
      check_eq("starve_alu_ready", 32'(last_alu_ready), (k == 3) ? 32'd0 : 32'd1);
      if (k == 3) begin
        check_eq("starve_pop_rd", 32'(rd_o), 32'd3);
        check_eq("starve_pop_data", wdata_o, 32'h33);
      end
    end
    alu_valid = 1'b0;

    // FIFO full while the ALU keeps the port busy.
    issue_long_op(5'd12);
    issue_long_op(5'd13);
    issue_long_op(5'd14);
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h1111;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC12;
    cycle();
    lsu_rd = 5'd13; lsu_data = 32'hC13;
    cycle();
    lsu_rd = 5'd14; lsu_data = 32'hC14;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (k == 0) check_eq("full_lsu_ready", 32'(last_lsu_ready), 32'd0);
      done = lsu_acc;
    end
    check_eq("full_third_accepted", 32'(done), 32'd1);
    lsu_valid = 1'b0;
    alu_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    check_eq("full_drained_busy", busy_mask, 32'd0);

    // x0 write is consumed silently.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    cycle();
    check_eq("x0_alu_ready", 32'(last_alu_ready), 32'd1);
    check_eq("x0_no_write", 32'(wen_o), 32'd0);
    alu_valid = 1'b0;

    // Same-cycle set and clear of x9: set wins.
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    cycle();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
    cycle();
    issue_valid = 1'b0; issue_long = 1'b0; issue_rd = '0;
    check_eq("collide_write_rd", 32'(rd_o), 32'd9);
    check_eq("collide_busy9", 32'(busy_mask[9]), 32'd1);

    // Random traffic, then drain every outstanding long op.
    alu_acc = 1'b0; lsu_acc = 1'b0;
    for (int n = 0; n < 400; n++) begin
      rand_stim(1'b0);
      cycle();
    end
    for (int n = 0; n < 120; n++) begin
      rand_stim(1'b1);
      cycle();
    end
    check_eq("final_busy_clear", busy_mask, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
